// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: register-file geometry and address type.
package wb_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NR_GPR       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result buffer: power-of-two depth FIFO with full/empty flags and a visible head.
module wb_load_fifo #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates execute vs. buffered load results onto the register-file
// write port and tracks outstanding loads for the decode hazard stall.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned LQ_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic                  issue_is_load,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  stall,
  output logic                  RegWEn,
  output logic [REG_ADDR_W-1:0] addr_towrite,
  output logic [XLEN-1:0]       data_towrite
);

  localparam int unsigned EW = REG_ADDR_W + XLEN;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic              lq_full;
  logic              lq_empty;
  logic              lq_push;
  logic              lq_pop;
  logic [EW-1:0]     lq_head;
  reg_addr_t         head_rd;
  logic [XLEN-1:0]   head_data;
  logic              ex_hs;
  logic              ld_issue;
  logic [SW-1:0]     starve_cnt;
  logic [NR_GPR-1:0] busy;
  logic [NR_GPR-1:0] busy_nxt;

  assign head_rd   = lq_head[EW-1 -: REG_ADDR_W];
  assign head_data = lq_head[XLEN-1:0];

  // Execute is held off only when a queued load has lost too many times in a row.
  assign ex_ready  = !((starve_cnt == SW'(STARVE_MAX)) && !lq_empty);
  assign lsu_ready = !lq_full;
  assign ex_hs     = ex_valid && ex_ready;
  assign lq_push   = lsu_valid && !lq_full;
  assign lq_pop    = !ex_hs && !lq_empty;

  // busy[0] is held at zero, so an x0 field can never raise the stall.
  assign stall    = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]);
  assign ld_issue = issue_valid && issue_is_load && !stall && (issue_rd != '0);

  wb_load_fifo #(
    .W     (EW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .wdata ({lsu_rd, lsu_data}),
    .pop   (lq_pop),
    .rdata (lq_head),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // A new load reservation beats a retiring load to the same register.
  always_comb begin
    busy_nxt = busy;
    if (lq_pop)   busy_nxt[head_rd]  = 1'b0;
    if (ld_issue) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (lq_pop)
        starve_cnt <= '0;
      else if (ex_hs && !lq_empty && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Commit register: x0 winners still load address/data but suppress the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWEn       <= 1'b0;
      addr_towrite <= '0;
      data_towrite <= '0;
    end else if (ex_hs) begin
      RegWEn       <= (ex_rd != '0);
      addr_towrite <= ex_rd;
      data_towrite <= ex_data;
    end else if (lq_pop) begin
      RegWEn       <= (head_rd != '0);
      addr_towrite <= head_rd;
      data_towrite <= head_data;
    end else begin
      RegWEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a
// transaction-level model (load queue, starvation count, busy set).
module tb_wb_stage;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned LQ_DEPTH   = 2;
  localparam int unsigned STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, lsu_valid, issue_valid, issue_is_load;
  logic        ex_ready, lsu_ready, stall, RegWEn;
  logic [4:0]  ex_rd, lsu_rd, issue_rd, issue_rs1, issue_rs2, addr_towrite;
  logic [31:0] ex_data, lsu_data, data_towrite;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
    .RegWEn(RegWEn), .addr_towrite(addr_towrite), .data_towrite(data_towrite)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  ld_t         mq[$];
  int          m_starve;
  bit [31:0]   m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_reserved(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  function automatic bit m_ex_ready();
    return !((m_starve == STARVE_MAX) && (mq.size() > 0));
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_reserved(issue_rs1) || m_reserved(issue_rs2) || m_reserved(issue_rd));
  endfunction

  task automatic m_reset();
    mq.delete();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  // One clock of the reference rules, evaluated on the pre-edge inputs and state.
  task automatic m_clock();
    int  n;
    bit  hs, popped, stl;
    ld_t head;
    n      = mq.size();
    hs     = ex_valid && m_ex_ready();
    popped = !hs && (n > 0);
    stl    = m_stall();
    if (n > 0) head = mq[0];
    if (hs) begin
      m_we = (ex_rd != 0); m_addr = ex_rd; m_data = ex_data;
    end else if (popped) begin
      m_we = (head.rd != 0); m_addr = head.rd; m_data = head.data;
    end else begin
      m_we = 1'b0;
    end
    if (popped) m_starve = 0;
    else if (hs && n > 0 && m_starve < STARVE_MAX) m_starve++;
    if (popped) m_busy[head.rd] = 1'b0;
    if (issue_valid && issue_is_load && !stl && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (popped) void'(mq.pop_front());
    if (lsu_valid && n < LQ_DEPTH) mq.push_back('{rd: lsu_rd, data: lsu_data});
  endtask

  task automatic drive(input logic exv, input logic [4:0] exr, input logic [31:0] exd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic iv, input logic il, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
    ex_valid = exv; ex_rd = exr; ex_data = exd;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    issue_valid = iv; issue_is_load = il; issue_rd = ir; issue_rs1 = r1; issue_rs2 = r2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check combinational outputs mid-cycle, clock once, then check the commit register.
  task automatic step();
    #1;
    chk("ex_ready", ex_ready, m_ex_ready());
    chk("lsu_ready", lsu_ready, (mq.size() < LQ_DEPTH));
    chk("stall", stall, m_stall());
    @(posedge clk);
    m_clock();
    #1;
    chk("RegWEn", RegWEn, m_we);
    chk("addr_towrite", addr_towrite, m_addr);
    chk("data_towrite", data_towrite, m_data);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_reset();
    #12;
    chk("rst_RegWEn", RegWEn, 0);
    chk("rst_addr", addr_towrite, 0);
    chk("rst_data", data_towrite, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Execute write lands for one cycle.
    drive(1, 5, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("exw_we", RegWEn, 1);
    chk("exw_addr", addr_towrite, 5);
    chk("exw_data", data_towrite, 32'h12345678);
    idle();
    step();
    chk("exw_we_drop", RegWEn, 0);

    // Load hazard on x7.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 2);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 0);
    #1 chk("hazard_stall", stall, 1);
    step();
    drive(0, 0, 0, 1, 7, 32'h0000CAFE, 1, 0, 8, 7, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 0);
    #1 chk("hazard_stall_held", stall, 1);
    step();
    chk("hazard_we", RegWEn, 1);
    chk("hazard_addr", addr_towrite, 7);
    chk("hazard_data", data_towrite, 32'h0000CAFE);
    chk("hazard_stall_clear", stall, 0);
    idle();
    step();

    // Buffer fills under continuous execute traffic; starvation forces both pops.
    drive(1, 9, 32'h100, 1, 3, 32'h333, 0, 0, 0, 0, 0);
    step();
    drive(1, 9, 32'h101, 1, 4, 32'h444, 0, 0, 0, 0, 0);
    step();
    #1 chk("full_lsu_ready", lsu_ready, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 10, 32'h200 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);
      if (i == 2) begin
        #1 chk("starve_ex_ready", ex_ready, 0);
      end
      step();
    end
    idle();
    step();

    // x0 destinations never raise the write enable but still drain the buffer.
    drive(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("x0_ex_we", RegWEn, 0);
    drive(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
    step();
    idle();
    step();
    chk("x0_ld_we", RegWEn, 0);
    chk("x0_ld_data", data_towrite, 32'hBEEF);
    chk("x0_ld_drained", lsu_ready, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    // Reset with two buffered loads and busy = {x7, x4}.
    drive(1, 9, 32'h1, 1, 4, 32'h4444, 1, 1, 4, 0, 0);
    step();
    drive(1, 9, 32'h2, 1, 7, 32'h7777, 1, 1, 7, 0, 0);
    step();
    drive(1, 9, 32'h3, 0, 0, 0, 1, 0, 8, 7, 4);
    #1 chk("pre_rst_stall", stall, 1);
    chk("pre_rst_full", lsu_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_RegWEn", RegWEn, 0);
    chk("mid_rst_addr", addr_towrite, 0);
    chk("mid_rst_data", data_towrite, 0);
    chk("mid_rst_ex_ready", ex_ready, 1);
    chk("mid_rst_lsu_ready", lsu_ready, 1);
    chk("mid_rst_stall", stall, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 8, 7, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_we", RegWEn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
